// File: rtl/serial_add32_ctrl.sv
// serial_add32_ctrl: 32-bit add/sub built from one 4-bit carry-lookahead slice.
// Processes one nibble per cycle, LSB first, chaining the carry through cr_q.
module serial_add32_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             start_i,
    input  logic             op_sub_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             co_o,
    output logic             ov_o
);
    localparam int N  = WIDTH / 4;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, r_q, result_q;
    logic [CW-1:0]    cnt_q;
    logic             cr_q, busy_q, done_q, co_q, ov_q;

    logic [3:0]       g, p, sum;
    logic             c1, c2, c3, c4;
    logic [WIDTH-1:0] r_d;

    assign g   = a_q[3:0] & b_q[3:0];
    assign p   = a_q[3:0] ^ b_q[3:0];
    assign c1  = g[0] | (p[0] & cr_q);
    assign c2  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cr_q);
    assign c3  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cr_q);
    assign c4  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & cr_q);
    assign sum = p ^ {c3, c2, c1, cr_q};
    // New nibble enters at the top so nibble 0 lands at bit 0 after N shifts.
    assign r_d = {sum, r_q[WIDTH-1:4]};

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            co_q     <= 1'b0;
            ov_q     <= 1'b0;
            cnt_q    <= '0;
            cr_q     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            r_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        a_q     <= a_i;
                        b_q     <= op_sub_i ? ~b_i : b_i;
                        cr_q    <= op_sub_i;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    a_q   <= a_q >> 4;
                    b_q   <= b_q >> 4;
                    r_q   <= r_d;
                    cr_q  <= c4;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(N - 1)) begin
                        result_q <= r_d;
                        co_q     <= c4;
                        ov_q     <= c3 ^ c4;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign result_o = result_q;
    assign co_o     = co_q;
    assign ov_o     = ov_q;
endmodule

// File: tb/tb_serial_add32_ctrl.sv
// tb_serial_add32_ctrl: directed vectors plus start-ignore and mid-op reset sequences.
module tb_serial_add32_ctrl;
    localparam int N = 8;

    logic        clk, reset_n, start, op_sub, busy, done, co, ov;
    logic [31:0] a, b, result;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_prev = '0;

    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        co;
        logic        ov;
    } vec_t;

    vec_t vecs[10];

    serial_add32_ctrl dut (
        .clk_i(clk), .reset_n_i(reset_n), .start_i(start), .op_sub_i(op_sub),
        .a_i(a), .b_i(b), .busy_o(busy), .done_o(done),
        .result_o(result), .co_o(co), .ov_o(ov)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one op; entered and left just after an edge, with the DUT idle.
    task automatic do_op(input string nm, input logic o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] er, input logic ec, input logic ev);
        logic ok;
        start = 1'b1; op_sub = o; a = x; b = y;
        tick();
        start = 1'b0; op_sub = ~o; a = ~x; b = ~y;
        ok = 1'b1;
        for (int k = 1; k <= N; k++) begin
            if (busy !== 1'b1 || done !== 1'b0 || result !== exp_prev) ok = 1'b0;
            tick();
        end
        chk({nm, "_busy_window"}, {31'b0, ok}, 32'd1);
        chk({nm, "_done"}, {31'b0, done}, 32'd1);
        chk({nm, "_busy_at_done"}, {31'b0, busy}, 32'd0);
        chk({nm, "_res"}, result, er);
        chk({nm, "_co"}, {31'b0, co}, {31'b0, ec});
        chk({nm, "_ov"}, {31'b0, ov}, {31'b0, ev});
        exp_prev = er;
        tick();
        chk({nm, "_done_pulse"}, {31'b0, done}, 32'd0);
    endtask

    initial begin
        int nd, done_at, waited;
        vecs[0] = '{1'b0, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1};
        vecs[3] = '{1'b1, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1};
        vecs[8] = '{1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b1};
        vecs[9] = '{1'b0, 32'h0000_FFFF, 32'h0000_0001, 32'h0001_0000, 1'b0, 1'b0};

        reset_n = 1'b0; start = 1'b0; op_sub = 1'b0; a = '0; b = '0;
        repeat (2) tick();
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_co", {31'b0, co}, 32'd0);
        chk("rst_ov", {31'b0, ov}, 32'd0);
        reset_n = 1'b1;
        tick();

        // start pulsed and then held during busy must be ignored until IDLE
        start = 1'b1; op_sub = 1'b0; a = 32'h1234_5678; b = 32'h1111_1111;
        tick();
        start = 1'b0;
        nd = 0; done_at = 0;
        for (int cyc = 1; cyc <= 11; cyc++) begin
            if (cyc == 2) begin start = 1'b1; op_sub = 1'b1; a = '1; b = '1; end
            if (cyc == 11) start = 1'b0;
            if (done === 1'b1) begin nd++; done_at = cyc; end
            if (busy === 1'b1 && done === 1'b1) chk("busy_and_done", 32'd1, 32'd0);
            if (cyc == 9) begin
                chk("ign_res", result, 32'h2345_6789);
                chk("ign_co", {31'b0, co}, 32'd0);
                chk("ign_ov", {31'b0, ov}, 32'd0);
            end
            if (cyc == 10) chk("ign_idle_c10", {31'b0, busy}, 32'd0);
            if (cyc == 11) chk("ign_accept_c10", {31'b0, busy}, 32'd1);
            tick();
        end
        chk("ign_done_count", nd, 32'd1);
        chk("ign_done_cycle", done_at, 32'd9);
        waited = 0;
        while (done !== 1'b1 && waited < 20) begin tick(); waited++; end
        chk("held_done_seen", {31'b0, done}, 32'd1);
        chk("held_res", result, 32'h0000_0000);
        chk("held_co", {31'b0, co}, 32'd1);
        chk("held_ov", {31'b0, ov}, 32'd0);
        exp_prev = 32'h0;
        tick();

        for (int i = 0; i < 10; i++)
            do_op($sformatf("v%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                  vecs[i].res, vecs[i].co, vecs[i].ov);

        // reset sampled at cycle 4 aborts the op and clears the held result
        start = 1'b1; op_sub = 1'b0; a = 32'h0000_1234; b = 32'h0000_4321;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        reset_n = 1'b0;
        tick();
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        chk("abort_result", result, 32'd0);
        chk("abort_co", {31'b0, co}, 32'd0);
        chk("abort_ov", {31'b0, ov}, 32'd0);
        reset_n = 1'b1;
        nd = 0;
        for (int k = 0; k < 12; k++) begin
            if (done === 1'b1) nd++;
            tick();
        end
        chk("abort_no_done", nd, 32'd0);
        exp_prev = 32'h0;
        do_op("post_rst", 1'b0, 32'd3, 32'd4, 32'h0000_0007, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/serial_add32_ctrl.md
# serial_add32_ctrl

Multi-cycle 32-bit add/subtract unit that time-shares a single 4-bit carry-lookahead slice. The slice provides the nibble sum, the carry into bit 3 (c3) and the carry out (co). A small FSM sequences the 4-bit slice over the operand nibbles, least significant first, and chains the carry through a register. It also derives unsigned carry/borrow and signed overflow for the ALU. It is the area-reduced alternative to the fully parallel 32-bit adder path in the ALU.

## Interface
- WIDTH, 32, operand width in bits; must be a multiple of 4; nibble count N = WIDTH/4
- clk  in  1  single clock, all state updates on rising edge
- reset_n  in  1  synchronous, active-low reset; sampled on rising edge of clk
- start  in  1  request to begin an operation; accepted only in IDLE
- op_sub  in  1  0 = a+b, 1 = a-b; sampled with start
- a  in  WIDTH  operand A; sampled with start
- b  in  WIDTH  operand B; sampled with start
- busy  out  1  high while nibbles are being processed
- done  out  1  one-cycle pulse; result/co/ov valid
- result  out  WIDTH  sum/difference; holds until next completion
- co  out  1  carry out of MSB nibble (sub: 1 = no borrow)
- ov  out  1  signed overflow = c3 XOR co of MSB nibble

## Operation
- One instance of the 4-bit CLA slice. Slice inputs are a_sh[3:0], b_sh[3:0] and carry register cr.
- States are IDLE, CALC and DONE.
- IDLE:
  - When start=1, latch a into a_sh.
  - Latch b into b_sh; store ~b when op_sub=1.
  - Set cr = op_sub, set nibble counter cnt = 0, then go to CALC.
  - When start=0, stay in IDLE.
- CALC, every cycle:
  - Slice sum nibble shifts into the top of internal r_sh; r_sh shifts right 4.
  - a_sh and b_sh shift right 4.
  - cr <= slice co.
  - cnt increments.
- CALC at cnt = N-1:
  - result <= final r_sh (including this nibble).
  - co <= slice co.
  - ov <= slice c3 ^ slice co.
  - Go to DONE.
- DONE: done=1 for this cycle only, then go to IDLE unconditionally.
- start is ignored in CALC and DONE; no queuing. Operand/op_sub changes after the start cycle have no effect.
- Arithmetic is modulo 2^WIDTH; the carry chain is exact two's complement (a + ~b + 1).

## Timing
- Reset (reset_n=0 at an edge) drives all of the following to 0:
  - busy, done, result, co, ov, cnt and cr.
  - FSM goes to IDLE.
- Reset mid-operation aborts the operation with no done pulse, and result clears to 0.
- Cycle numbering, with cycle 0 = edge at which start is sampled in IDLE:
  - Cycles 1..N: busy=1, nibble k processed in cycle k+1.
  - Cycle N+1: done=1, busy=0, result/co/ov already updated.
  - Cycle N+2: IDLE; the earliest new start is sampled here.
- Latency is start to done = N+1 cycles (9 for WIDTH=32). Throughput is one operation per N+2 cycles.
- busy and done are never high together.
- result/co/ov change only at the edge entering DONE (or on reset). They are stable during busy, holding the previous result.
- start held high continuously: a new operation begins every N+2 cycles, at each IDLE.

## Test plan
- add a=0x0000_0001, b=0xFFFF_FFFF:
  - result=0x0000_0000, co=1, ov=0.
  - done exactly 9 cycles after start; busy high cycles 1–8.
- add a=0x7FFF_FFFF, b=0x0000_0001 -> result=0x8000_0000, co=0, ov=1.
- sub a=0x8000_0000, b=0x0000_0001 -> result=0x7FFF_FFFF, co=1, ov=1.
- sub a=0x0000_0005, b=0x0000_0007 -> result=0xFFFF_FFFE, co=0, ov=0.
- Start add 0x1234_5678+0x1111_1111, then during busy pulse start with a=b=0xFFFF_FFFF and change a/b:
  - Only one done.
  - result=0x2345_6789, co=0, ov=0.
  - Next start is accepted only in cycle 10.
- Start any op, assert reset_n=0 at cycle 4:
  - Next cycle busy=0, done=0, result=0, co=0, ov=0, and no done pulse follows.
  - A fresh add 3+4 then completes with result=0x0000_0007 after 9 cycles.
